// File: rtl/sha256_job_scheduler_if.sv
// sha256_job_scheduler_if
// Bundles the requester-side handshake and the SHA core control pins.
// The slave modport is the scheduler's view. The master modport is the
// environment's view: the requester fabric plus the core that returns done.

interface sha256_job_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [16*NUM_REQ-1:0] req_msg_addr;
   logic [16*NUM_REQ-1:0] req_out_addr;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    cmp_valid;
   logic                  cmp_err;
   logic                  core_start;
   logic [15:0]           core_message_addr;
   logic [15:0]           core_output_addr;
   logic                  core_done;
   logic                  busy;
   logic [ID_W-1:0]       grant_id;
   logic [15:0]           job_count;

   modport slave (
      input  req_valid, req_msg_addr, req_out_addr, core_done,
      output req_ready, cmp_valid, cmp_err, core_start,
             core_message_addr, core_output_addr, busy, grant_id, job_count
   );

   modport master (
      output req_valid, req_msg_addr, req_out_addr, core_done,
      input  req_ready, cmp_valid, cmp_err, core_start,
             core_message_addr, core_output_addr, busy, grant_id, job_count
   );
endinterface

// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler
// Shares one SHA-256 core among NUM_REQ requesters. A round-robin arbiter
// picks a requester while the core is idle, latches its addresses, pulses
// core_start, follows the core's done handshake and returns a one-cycle
// completion pulse to the requester that owned the job.
// Optional build macro SHA_SCHED_WDOG_EN adds a per-job watchdog that aborts
// a job after WDOG_CYCLES clocks and flags the completion with cmp_err.

module sha256_job_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int WDOG_CYCLES = 1024
) (
   input logic                   clk,
   input logic                   reset_n,
   sha256_job_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BUSY = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

`ifdef SHA_SCHED_WDOG_EN
   localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES - 1);
`else
   // Keeps the watchdog limit referenced when the watchdog is compiled out.
   localparam int unused_wdog_cycles = WDOG_CYCLES;
`endif

   state_t               state_r;
   logic [ID_W-1:0]      rr_ptr_r;
   logic [NUM_REQ-1:0]   req_ready_r;
   logic [NUM_REQ-1:0]   cmp_valid_r;
   logic                 cmp_err_r;
   logic                 core_start_r;
   logic [15:0]          msg_addr_r;
   logic [15:0]          out_addr_r;
   logic                 busy_r;
   logic [ID_W-1:0]      grant_id_r;
   logic [15:0]          job_count_r;
`ifdef SHA_SCHED_WDOG_EN
   logic [15:0]          wdog_cnt_r;
`endif

   logic [2*NUM_REQ-1:0] req_dbl_s;
   logic [NUM_REQ-1:0]   req_rot_s;
   logic                 found_s;
   logic [ID_W-1:0]      win_off_s;
   logic [ID_W:0]        win_sum_s;
   logic [ID_W:0]        win_wrap_s;
   logic [ID_W-1:0]      winner_s;
   logic [NUM_REQ-1:0]   grant_onehot_s;
   logic [ID_W-1:0]      rr_next_s;

   // Round-robin winner: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
   always_comb begin
      req_dbl_s = {bus.req_valid, bus.req_valid};
      req_rot_s = req_dbl_s[rr_ptr_r +: NUM_REQ];
      found_s   = |req_rot_s;
      win_off_s = '0;
      // Scanning downward lets the lowest set offset win the last assignment.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot_s[k]) begin
            win_off_s = ID_W'(k);
         end else begin
            win_off_s = win_off_s;
         end
      end
      win_sum_s  = {1'b0, rr_ptr_r} + {1'b0, win_off_s};
      win_wrap_s = win_sum_s - NUM_REQ_W;
      if (win_sum_s >= NUM_REQ_W) begin
         winner_s = win_wrap_s[ID_W-1:0];
      end else begin
         winner_s = win_sum_s[ID_W-1:0];
      end
   end

   // Completion target and the pointer value that follows the current grant.
   always_comb begin
      grant_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
      if (grant_id_r == LAST_ID) begin
         rr_next_s = '0;
      end else begin
         rr_next_s = grant_id_r + ID_W'(1);
      end
   end

   // Scheduler FSM: grant in IDLE, watch core_done fall then rise, report completion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         rr_ptr_r     <= '0;
         req_ready_r  <= '0;
         cmp_valid_r  <= '0;
         cmp_err_r    <= 1'b0;
         core_start_r <= 1'b0;
         msg_addr_r   <= 16'h0000;
         out_addr_r   <= 16'h0000;
         busy_r       <= 1'b0;
         grant_id_r   <= '0;
         job_count_r  <= 16'h0000;
`ifdef SHA_SCHED_WDOG_EN
         wdog_cnt_r   <= 16'h0000;
`endif
      end else begin
         // Pulses are single-cycle unless re-armed below.
         req_ready_r  <= '0;
         core_start_r <= 1'b0;
         cmp_valid_r  <= '0;
         cmp_err_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // A core busy on someone else's behalf blocks arbitration.
               if (bus.core_done && found_s) begin
                  msg_addr_r            <= bus.req_msg_addr[{winner_s, 4'b0000} +: 16];
                  out_addr_r            <= bus.req_out_addr[{winner_s, 4'b0000} +: 16];
                  grant_id_r            <= winner_s;
                  req_ready_r[winner_s] <= 1'b1;
                  core_start_r          <= 1'b1;
                  busy_r                <= 1'b1;
                  state_r               <= ST_WAIT_BUSY;
`ifdef SHA_SCHED_WDOG_EN
                  wdog_cnt_r            <= 16'h0000;
`endif
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WAIT_BUSY: begin
`ifdef SHA_SCHED_WDOG_EN
               if (wdog_cnt_r == WDOG_LIMIT) begin
                  cmp_valid_r <= grant_onehot_s;
                  cmp_err_r   <= 1'b1;
                  rr_ptr_r    <= rr_next_s;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end else if (!bus.core_done) begin
                  wdog_cnt_r <= wdog_cnt_r + 16'd1;
                  state_r    <= ST_WAIT_DONE;
               end else begin
                  wdog_cnt_r <= wdog_cnt_r + 16'd1;
               end
`else
               // The core lowers done one clock after it samples start.
               if (!bus.core_done) begin
                  state_r <= ST_WAIT_DONE;
               end else begin
                  state_r <= ST_WAIT_BUSY;
               end
`endif
            end
            ST_WAIT_DONE: begin
               if (bus.core_done) begin
                  cmp_valid_r <= grant_onehot_s;
                  job_count_r <= job_count_r + 16'd1;
                  rr_ptr_r    <= rr_next_s;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
`ifdef SHA_SCHED_WDOG_EN
               end else if (wdog_cnt_r == WDOG_LIMIT) begin
                  // Abort: the job is reported but not counted as completed.
                  cmp_valid_r <= grant_onehot_s;
                  cmp_err_r   <= 1'b1;
                  rr_ptr_r    <= rr_next_s;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end else begin
                  wdog_cnt_r <= wdog_cnt_r + 16'd1;
               end
`else
               end else begin
                  state_r <= ST_WAIT_DONE;
               end
`endif
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready         = req_ready_r;
   assign bus.cmp_valid         = cmp_valid_r;
   assign bus.cmp_err           = cmp_err_r;
   assign bus.core_start        = core_start_r;
   assign bus.core_message_addr = msg_addr_r;
   assign bus.core_output_addr  = out_addr_r;
   assign bus.busy              = busy_r;
   assign bus.grant_id          = grant_id_r;
   assign bus.job_count         = job_count_r;

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// tb_sha256_job_scheduler
// Directed bench for sha256_job_scheduler: table of single jobs plus
// hand-written sequences for fairness, pointer wrap, address hold,
// mid-job reset and the watchdog (SHA_SCHED_WDOG_EN) behaviour.

module tb_sha256_job_scheduler;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic clk = 1'b0;
   logic reset_n;

   int   errors = 0;
   int   checks = 0;
   int   core_lat = 20;
   bit   core_hang = 1'b0;
   int   core_cnt;

   always #5 clk = ~clk;

   sha256_job_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   sha256_job_scheduler #(
      .NUM_REQ(NUM_REQ),
      .ID_W(ID_W),
      .WDOG_CYCLES(64)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   // Core model: drops done one clock after sampling start, raises it core_lat clocks later.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.core_done <= 1'b1;
         core_cnt      <= 0;
      end else if (bus.core_done) begin
         if (bus.core_start) begin
            bus.core_done <= 1'b0;
            core_cnt      <= core_lat;
         end
      end else if (!core_hang) begin
         if (core_cnt <= 1) bus.core_done <= 1'b1;
         else core_cnt <= core_cnt - 1;
      end
   end

   typedef struct {
      logic [3:0]  rv;
      logic [63:0] msg;
      logic [63:0] outa;
      int          exp_grant;
      logic [15:0] exp_msg;
      logic [15:0] exp_out;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Returns number of negedges waited until req_ready is seen, or -1.
   task automatic wait_ready(input string tag, output int lat);
      lat = -1;
      for (int t = 1; t <= 30 && lat < 0; t++) begin
         @(negedge clk);
         if (bus.req_ready != 4'b0000) lat = t;
      end
      check({tag, " ready timeout"}, 64'(lat >= 0), 64'd1);
   endtask

   // Returns negedges until cmp_valid, and how long after done rose it came.
   task automatic wait_cmp(input string tag, output int lat, output int after_done);
      bit seen_low = 1'b0;
      int done_at = -1;
      lat = -1;
      for (int t = 1; t <= core_lat + 100 && lat < 0; t++) begin
         @(negedge clk);
         if (bus.cmp_valid != 4'b0000) lat = t;
         else if (!bus.core_done) seen_low = 1'b1;
         else if (seen_low && done_at < 0) done_at = t;
      end
      after_done = (done_at < 0) ? -1 : lat - done_at;
      check({tag, " cmp timeout"}, 64'(lat >= 0), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      bus.req_valid = 4'b0000;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_job(input vec_t v, input string tag);
      int lat;
      int ad;
      logic [3:0] oh;
      oh = 4'b0001 << v.exp_grant;
      bus.req_msg_addr = v.msg;
      bus.req_out_addr = v.outa;
      bus.req_valid    = v.rv;
      wait_ready(tag, lat);
      check({tag, " ready latency"}, 64'(lat), 64'd1);
      check({tag, " req_ready"}, 64'(bus.req_ready), 64'(oh));
      check({tag, " core_start"}, 64'(bus.core_start), 64'd1);
      check({tag, " grant_id"}, 64'(bus.grant_id), 64'(v.exp_grant));
      check({tag, " msg_addr"}, 64'(bus.core_message_addr), 64'(v.exp_msg));
      check({tag, " out_addr"}, 64'(bus.core_output_addr), 64'(v.exp_out));
      check({tag, " busy"}, 64'(bus.busy), 64'd1);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      check({tag, " pulses clear"}, 64'({bus.req_ready, bus.core_start}), 64'd0);
      wait_cmp(tag, lat, ad);
      check({tag, " cmp_valid"}, 64'(bus.cmp_valid), 64'(oh));
      check({tag, " cmp after done"}, 64'(ad), 64'd1);
      check({tag, " cmp_err"}, 64'(bus.cmp_err), 64'd0);
      check({tag, " job_count"}, 64'(bus.job_count), 64'(v.exp_cnt));
      check({tag, " idle busy"}, 64'(bus.busy), 64'd0);
      @(negedge clk);
      check({tag, " cmp one cycle"}, 64'(bus.cmp_valid), 64'd0);
   endtask

   initial begin
      int lat;
      int ad;
      bit cmp_seen;
      logic [63:0] msg_all;
      logic [63:0] out_all;

      msg_all = {16'h3300, 16'h2200, 16'h1100, 16'h0100};
      out_all = {16'h3310, 16'h2210, 16'h1210, 16'h0110};
      vecs[0] = '{4'b0001, 64'h0, 64'h10, 0, 16'h0000, 16'h0010, 16'd1};
      vecs[1] = '{4'b1111, msg_all, out_all, 1, 16'h1100, 16'h1210, 16'd2};
      vecs[2] = '{4'b1001, msg_all, out_all, 3, 16'h3300, 16'h3310, 16'd3};
      vecs[3] = '{4'b1010, msg_all, out_all, 1, 16'h1100, 16'h1210, 16'd4};
      vecs[4] = '{4'b0001, msg_all, out_all, 0, 16'h0100, 16'h0110, 16'd5};
      vecs[5] = '{4'b0100, msg_all, out_all, 2, 16'h2200, 16'h2210, 16'd6};

      reset_n          = 1'b0;
      bus.req_valid    = 4'b0000;
      bus.req_msg_addr = 64'h0;
      bus.req_out_addr = 64'h0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset grant_id", 64'(bus.grant_id), 64'd0);
      check("reset job_count", 64'(bus.job_count), 64'd0);
      check("reset pulses", 64'({bus.req_ready, bus.cmp_valid, bus.cmp_err, bus.core_start}), 64'd0);
      check("reset addrs", 64'({bus.core_message_addr, bus.core_output_addr}), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Table of single jobs; rr pointer carries from row to row.
      for (int i = 0; i < 6; i++) begin
         run_job(vecs[i], $sformatf("vec%0d", i));
      end

      // Fairness: all four held, each re-raised after its accept.
      do_reset();
      bus.req_msg_addr = msg_all;
      bus.req_out_addr = out_all;
      bus.req_valid    = 4'b1111;
      for (int j = 0; j < 8; j++) begin
         wait_ready($sformatf("rr%0d", j), lat);
         check($sformatf("rr%0d grant_id", j), 64'(bus.grant_id), 64'(j % 4));
         check($sformatf("rr%0d req_ready", j), 64'(bus.req_ready), 64'(4'b0001 << (j % 4)));
         bus.req_valid = 4'b1111 & ~(4'b0001 << (j % 4));
         @(negedge clk);
         bus.req_valid = 4'b1111;
         wait_cmp($sformatf("rr%0d", j), lat, ad);
         check($sformatf("rr%0d cmp_valid", j), 64'(bus.cmp_valid), 64'(4'b0001 << (j % 4)));
         if (j == 7) bus.req_valid = 4'b0000;
      end
      check("rr job_count", 64'(bus.job_count), 64'd8);
      @(negedge clk);
      check("rr quiet", 64'(bus.req_ready), 64'd0);

      // Pointer wrap: grant 2, then 0110 waiting during the job must yield 1.
      bus.req_valid = 4'b0100;
      wait_ready("wrap first", lat);
      check("wrap first grant", 64'(bus.grant_id), 64'd2);
      bus.req_valid = 4'b0000;
      repeat (5) @(negedge clk);
      bus.req_valid = 4'b0110;
      wait_cmp("wrap first", lat, ad);
      check("wrap cmp_valid", 64'(bus.cmp_valid), 64'(4'b0100));
      check("wrap no grant in cmp cycle", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      check("wrap second ready", 64'(bus.req_ready), 64'(4'b0010));
      check("wrap second grant", 64'(bus.grant_id), 64'd1);
      bus.req_valid = 4'b0000;
      wait_cmp("wrap second", lat, ad);
      check("wrap job_count", 64'(bus.job_count), 64'd10);
      @(negedge clk);

      // Reset during WAIT_DONE with rr_ptr=2.
      bus.req_valid = 4'b0010;
      wait_ready("rst job", lat);
      check("rst job grant", 64'(bus.grant_id), 64'd1);
      bus.req_valid = 4'b0000;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst busy", 64'(bus.busy), 64'd0);
      check("rst grant_id", 64'(bus.grant_id), 64'd0);
      check("rst job_count", 64'(bus.job_count), 64'd0);
      check("rst addrs", 64'({bus.core_message_addr, bus.core_output_addr}), 64'd0);
      cmp_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         cmp_seen = cmp_seen | (bus.cmp_valid != 4'b0000);
      end
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         cmp_seen = cmp_seen | (bus.cmp_valid != 4'b0000);
      end
      check("rst no cmp", 64'(cmp_seen), 64'd0);
      bus.req_valid = 4'b1101;
      wait_ready("post rst", lat);
      check("post rst grant", 64'(bus.grant_id), 64'd0);
      bus.req_valid = 4'b0000;
      wait_cmp("post rst", lat, ad);
      check("post rst job_count", 64'(bus.job_count), 64'd1);
      @(negedge clk);

      // Address hold: slice changes during WAIT_DONE must not leak through.
      bus.req_msg_addr = {16'h0020, 48'h0};
      bus.req_out_addr = {16'h0030, 48'h0};
      bus.req_valid    = 4'b1000;
      wait_ready("hold", lat);
      check("hold grant", 64'(bus.grant_id), 64'd3);
      bus.req_valid = 4'b0000;
      repeat (5) @(negedge clk);
      bus.req_msg_addr = {16'h0040, 48'h0};
      bus.req_out_addr = {16'h0050, 48'h0};
      check("hold msg mid", 64'(bus.core_message_addr), 64'h20);
      wait_cmp("hold", lat, ad);
      check("hold msg at cmp", 64'(bus.core_message_addr), 64'h20);
      check("hold out at cmp", 64'(bus.core_output_addr), 64'h30);
      @(negedge clk);

      // Core never finishes.
      core_hang     = 1'b1;
      bus.req_valid = 4'b0001;
      wait_ready("wdog", lat);
      check("wdog grant", 64'(bus.grant_id), 64'd0);
      bus.req_valid = 4'b0000;
`ifdef SHA_SCHED_WDOG_EN
      wait_cmp("wdog", lat, ad);
      check("wdog delay", 64'(lat), 64'd64);
      check("wdog cmp_valid", 64'(bus.cmp_valid), 64'(4'b0001));
      check("wdog cmp_err", 64'(bus.cmp_err), 64'd1);
      check("wdog job_count", 64'(bus.job_count), 64'd2);
      check("wdog busy", 64'(bus.busy), 64'd0);
`else
      cmp_seen = 1'b0;
      repeat (200) begin
         @(negedge clk);
         cmp_seen = cmp_seen | (bus.cmp_valid != 4'b0000);
      end
      check("hang no cmp", 64'(cmp_seen), 64'd0);
      check("hang busy", 64'(bus.busy), 64'd1);
      check("hang job_count", 64'(bus.job_count), 64'd2);
`endif
      core_hang = 1'b0;
      do_reset();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
